// File: rtl/crack_pkg.sv
// Shared types and defaults for the ARC4 key-search scheduler.
// Holds the FSM state encoding and the printable-byte test used by the scanner.
package crack_pkg;

   localparam int         KEY_W   = 24;
   localparam logic [7:0] CHAR_LO = 8'h20;
   localparam logic [7:0] CHAR_HI = 8'h7E;

   typedef enum logic [2:0] {
      IDLE,
      START,
      BUSY,
      RD_LEN,
      CHECK,
      NEXT,
      FOUND,
      DONE
   } state_t;

   function automatic logic is_printable(input logic [7:0] b,
                                         input logic [7:0] lo,
                                         input logic [7:0] hi);
      return (b >= lo) && (b <= hi);
   endfunction

endpackage

// File: rtl/crack_ctrl.sv
// Key-search scheduler: starts arc4 once per key, then scans the length-prefixed
// plaintext one byte per two cycles, stopping on the first all-printable key or at KEY_LAST.
module crack_ctrl
   import crack_pkg::*;
#(
   parameter int               KEY_W     = crack_pkg::KEY_W,
   parameter logic [KEY_W-1:0] KEY_FIRST = '0,
   parameter logic [KEY_W-1:0] KEY_LAST  = '1,
   parameter logic [7:0]       CHAR_LO   = crack_pkg::CHAR_LO,
   parameter logic [7:0]       CHAR_HI   = crack_pkg::CHAR_HI
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic             rdy,
   output logic [KEY_W-1:0] key,
   output logic             key_valid,
   output logic             arc4_en,
   input  logic             arc4_rdy,
   output logic [7:0]       pt_addr,
   input  logic [7:0]       pt_rddata
);

   state_t           state, state_nxt;
   logic             rdy_nxt, key_valid_nxt, arc4_en_nxt;
   logic [KEY_W-1:0] key_nxt;
   logic [7:0]       pt_addr_nxt, len, len_nxt;
   logic [8:0]       idx, idx_nxt, idx_inc;
   // phase: in BUSY = arc4_rdy has been seen low; in RD_LEN/CHECK = data cycle.
   logic             phase, phase_nxt;

   assign idx_inc = idx + 9'd1;

   always_comb begin
      state_nxt     = state;
      rdy_nxt       = rdy;
      key_nxt       = key;
      key_valid_nxt = key_valid;
      arc4_en_nxt   = 1'b0;
      pt_addr_nxt   = pt_addr;
      len_nxt       = len;
      idx_nxt       = idx;
      phase_nxt     = phase;
      case (state)
         IDLE: begin
            if (en) begin
               key_nxt       = KEY_FIRST;
               key_valid_nxt = 1'b0;
               rdy_nxt       = 1'b0;
               state_nxt     = START;
            end
         end
         START: begin
            if (arc4_rdy) begin
               arc4_en_nxt = 1'b1;
               phase_nxt   = 1'b0;
               state_nxt   = BUSY;
            end
         end
         BUSY: begin
            if (!phase) begin
               if (!arc4_rdy) phase_nxt = 1'b1;
            end else if (arc4_rdy) begin
               pt_addr_nxt = 8'd0;
               phase_nxt   = 1'b0;
               state_nxt   = RD_LEN;
            end
         end
         RD_LEN: begin
            if (!phase) begin
               phase_nxt = 1'b1;
            end else begin
               len_nxt     = pt_rddata;
               idx_nxt     = 9'd1;
               pt_addr_nxt = 8'd1;
               phase_nxt   = 1'b0;
               state_nxt   = (pt_rddata == 8'd0) ? FOUND : CHECK;
            end
         end
         CHECK: begin
            if (!phase) begin
               phase_nxt = 1'b1;
            end else if (!is_printable(pt_rddata, CHAR_LO, CHAR_HI)) begin
               state_nxt = NEXT;
            end else if (idx == {1'b0, len}) begin
               state_nxt = FOUND;
            end else begin
               idx_nxt     = idx_inc;
               pt_addr_nxt = idx_inc[7:0];
               phase_nxt   = 1'b0;
            end
         end
         NEXT: begin
            if (key == KEY_LAST) begin
               state_nxt = DONE;
            end else begin
               key_nxt   = key + KEY_W'(1);
               state_nxt = START;
            end
         end
         FOUND: begin
            key_valid_nxt = 1'b1;
            rdy_nxt       = 1'b1;
            state_nxt     = IDLE;
         end
         DONE: begin
            rdy_nxt   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rdy       <= 1'b1;
         key       <= KEY_FIRST;
         key_valid <= 1'b0;
         arc4_en   <= 1'b0;
         pt_addr   <= 8'd0;
         len       <= 8'd0;
         idx       <= 9'd0;
         phase     <= 1'b0;
      end else begin
         state     <= state_nxt;
         rdy       <= rdy_nxt;
         key       <= key_nxt;
         key_valid <= key_valid_nxt;
         arc4_en   <= arc4_en_nxt;
         pt_addr   <= pt_addr_nxt;
         len       <= len_nxt;
         idx       <= idx_nxt;
         phase     <= phase_nxt;
      end
   end

endmodule

// File: tb/tb_crack_ctrl.sv
// Directed bench for crack_ctrl: two instances (keys 0.. and 5..7) each driven by a
// behavioural arc4 stub whose PT memory is loaded from a per-scenario, per-key table.
module tb_crack_ctrl;

   localparam int KW       = 24;
   localparam int BUSY_CYC = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [1:0]    en, rdy, key_valid, arc4_en, arc4_rdy;
   logic [KW-1:0] key       [2];
   logic [7:0]    pt_addr   [2];
   logic [7:0]    pt_rddata [2];

   int n_cmp = 0;
   int n_bad = 0;
   int scen = 0;
   int hold_extra = 0;

   int   pulses     [2] = '{0, 0};
   int   dup        [2] = '{0, 0};
   int   addr_at_en [2] = '{0, 0};
   int   cnt        [2];
   int   hcnt       [2];
   logic pend       [2];
   logic en_d       [2];
   logic [7:0] mem  [2][256];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      crack_ctrl #(
         .KEY_W    (KW),
         .KEY_FIRST(g == 0 ? 24'h000000 : 24'h000005),
         .KEY_LAST (g == 0 ? 24'hFFFFFF : 24'h000007)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .en       (en[g]),
         .rdy      (rdy[g]),
         .key      (key[g]),
         .key_valid(key_valid[g]),
         .arc4_en  (arc4_en[g]),
         .arc4_rdy (arc4_rdy[g]),
         .pt_addr  (pt_addr[g]),
         .pt_rddata(pt_rddata[g])
      );
   end

   // Plaintext table: byte at address a for key k in scenario s (address 0 is the length).
   function automatic logic [7:0] pt_byte(input int s, input logic [KW-1:0] k, input int a);
      logic [7:0] r;
      r = 8'h00;
      case (s)
         1, 2: begin
            if ((s == 2) && (k == 24'd0)) begin
               r = (a == 0) ? 8'd50 : (a == 1) ? 8'h1F : 8'h41;
            end else if (((s == 1) && (k == 24'd3)) || ((s == 2) && (k == 24'd1))) begin
               r = (a == 0) ? 8'd2 : (a == 1) ? 8'h48 : (a == 2) ? 8'h69 : 8'h00;
            end else begin
               r = (a == 0) ? 8'd1 : (a == 1) ? 8'h01 : 8'h00;
            end
         end
         3: r = (a == 0) ? 8'd1 : (a == 1) ? 8'h7F : 8'h00;
         4: r = 8'h00;
         5: r = (a == 0) ? 8'hFF : 8'h7E;
         6: begin
            if (k == 24'd0) r = (a == 0) ? 8'd3 : (a == 1) ? 8'h20 : (a == 2) ? 8'h7E : 8'h7F;
            else            r = (a == 0) ? 8'd2 : (a == 1) ? 8'h20 : 8'h7E;
         end
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // arc4 stub plus observers for start pulses and the address held when the next key starts.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            arc4_rdy[i] <= 1'b1;
            cnt[i]      <= 0;
            hcnt[i]     <= 0;
            pend[i]     <= 1'b0;
            en_d[i]     <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            pt_rddata[i] <= mem[i][pt_addr[i]];
            en_d[i]      <= arc4_en[i];
            if (arc4_en[i]) begin
               pulses[i]     <= pulses[i] + 1;
               addr_at_en[i] <= int'(pt_addr[i]);
               if (en_d[i]) dup[i] <= dup[i] + 1;
            end
            if (arc4_en[i] && arc4_rdy[i] && !pend[i]) begin
               if (hold_extra == 0) begin
                  arc4_rdy[i] <= 1'b0;
                  cnt[i]      <= BUSY_CYC;
               end else begin
                  pend[i] <= 1'b1;
                  hcnt[i] <= hold_extra - 1;
               end
            end else if (pend[i]) begin
               if (hcnt[i] == 0) begin
                  pend[i]     <= 1'b0;
                  arc4_rdy[i] <= 1'b0;
                  cnt[i]      <= BUSY_CYC;
               end else begin
                  hcnt[i] <= hcnt[i] - 1;
               end
            end else if (!arc4_rdy[i]) begin
               if (cnt[i] == 0) begin
                  arc4_rdy[i] <= 1'b1;
                  for (int a = 0; a < 256; a++) mem[i][a] <= pt_byte(scen, key[i], a);
               end else begin
                  cnt[i] <= cnt[i] - 1;
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start_search(input int g);
      @(negedge clk) en[g] = 1'b1;
      @(negedge clk) en[g] = 1'b0;
      check("rdy_drop", {31'd0, rdy[g]}, 32'd0);
   endtask

   task automatic wait_done(input int g, input int budget);
      for (int c = 0; c < budget && !rdy[g]; c++) @(negedge clk);
      check("done_in_time", {31'd0, rdy[g]}, 32'd1);
   endtask

   int p0;

   initial begin
      rst_n = 1'b0;
      en    = 2'b00;
      #12;
      check("rst_rdy",       {30'd0, rdy},       32'h3);
      check("rst_key_valid", {30'd0, key_valid}, 32'h0);
      check("rst_arc4_en",   {30'd0, arc4_en},   32'h0);
      check("rst_pt_addr",   {24'd0, pt_addr[0]}, 32'h0);
      check("rst_key0",      {8'd0, key[0]},     32'h0);
      check("rst_key1",      {8'd0, key[1]},     32'h5);
      @(negedge clk) rst_n = 1'b1;

      // Key hit on key 3
      scen = 1; p0 = pulses[0];
      start_search(0);
      wait_done(0, 400);
      check("hit_pulses", pulses[0] - p0, 4);
      check("hit_valid",  {31'd0, key_valid[0]}, 32'd1);
      check("hit_key",    {8'd0, key[0]}, 32'h3);
      check("hit_dup",    dup[0], 0);

      // Early exit at bad byte 0x1F, idx 1 of 50
      scen = 2; p0 = pulses[0];
      start_search(0);
      wait_done(0, 400);
      check("early_pulses",   pulses[0] - p0, 2);
      check("early_key",      {8'd0, key[0]}, 32'h1);
      check("early_valid",    {31'd0, key_valid[0]}, 32'd1);
      check("early_last_adr", addr_at_en[0], 1);

      // Exhaustion over keys 5..7; 0x7F rejected
      scen = 3; p0 = pulses[1];
      start_search(1);
      wait_done(1, 400);
      check("exh_pulses", pulses[1] - p0, 3);
      check("exh_valid",  {31'd0, key_valid[1]}, 32'd0);
      check("exh_key",    {8'd0, key[1]}, 32'h7);

      // Empty message accepts first key
      scen = 4; p0 = pulses[0];
      start_search(0);
      wait_done(0, 200);
      check("len0_pulses", pulses[0] - p0, 1);
      check("len0_key",    {8'd0, key[0]}, 32'h0);
      check("len0_valid",  {31'd0, key_valid[0]}, 32'd1);

      // len=255, all 0x7E
      scen = 5; p0 = pulses[0];
      start_search(0);
      wait_done(0, 1000);
      check("len255_pulses", pulses[0] - p0, 1);
      check("len255_key",    {8'd0, key[0]}, 32'h0);
      check("len255_valid",  {31'd0, key_valid[0]}, 32'd1);
      check("len255_addr",   {24'd0, pt_addr[0]}, 32'd255);

      // 0x20/0x7E pass, 0x7F fails at addr 3
      scen = 6; p0 = pulses[0];
      start_search(0);
      wait_done(0, 400);
      check("edge_key",      {8'd0, key[0]}, 32'h1);
      check("edge_valid",    {31'd0, key_valid[0]}, 32'd1);
      check("edge_last_adr", addr_at_en[0], 3);

      // Async reset while the third key's start pulse is high
      scen = 1; p0 = pulses[0];
      start_search(0);
      for (int c = 0; c < 400 && !(arc4_en[0] && (pulses[0] - p0) == 2); c++) @(negedge clk);
      check("arst_reached", {31'd0, arc4_en[0]}, 32'd1);
      check("arst_key_pre", {8'd0, key[0]}, 32'h2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_rdy",     {31'd0, rdy[0]}, 32'd1);
      check("arst_arc4_en", {31'd0, arc4_en[0]}, 32'd0);
      check("arst_key",     {8'd0, key[0]}, 32'h0);
      check("arst_valid",   {31'd0, key_valid[0]}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      p0 = pulses[0];
      start_search(0);
      wait_done(0, 400);
      check("restart_pulses", pulses[0] - p0, 4);
      check("restart_key",    {8'd0, key[0]}, 32'h3);

      // Stray en while busy, arc4_rdy held high 3 extra cycles after start
      hold_extra = 3; scen = 1; p0 = pulses[0];
      start_search(0);
      for (int k = 0; k < 30; k++) @(negedge clk) en[0] = ((k % 7) == 3);
      en[0] = 1'b0;
      wait_done(0, 400);
      check("hold_pulses", pulses[0] - p0, 4);
      check("hold_key",    {8'd0, key[0]}, 32'h3);
      check("hold_valid",  {31'd0, key_valid[0]}, 32'd1);
      check("hold_dup",    dup[0], 0);
      hold_extra = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
